// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage: bubble pattern, reset PC,
// FSM encodings and a small PC helper.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Forces a redirect target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// Generic IF/ID pipeline register. Bubble wins over load; neither means hold.
import instruction_fetch_stage_pkg::*;

module if_id_register #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // Pipeline register: reset to an invalid NOP, then bubble / load / hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end else begin
      pc_q    <= pc_q;
      pc4_q   <= pc4_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end
  end

  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I instruction fetch stage: PC, imem read handshake with wait states,
// stall buffering, redirect draining, and the IF/ID register.
import instruction_fetch_stage_pkg::*;

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INSTRUCTION,
  output logic        IFID_VALID,
  output logic        FETCH_BUSY
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         ifid_load_s;
  logic         ifid_bubble_s;
  logic [31:0]  ifid_instr_in_s;
  logic [31:0]  target_s;

  assign target_s = word_align(BRANCH_TARGET);

  // State, PC, stall buffer and pending redirect registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_REQ;
      pc_q      <= word_align(RESET_PC);
      buf_q     <= 32'd0;
      pend_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-state logic; FLUSH outranks STALL and the memory response.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_d           = buf_q;
    pend_pc_d       = pend_pc_q;
    ifid_load_s     = 1'b0;
    ifid_bubble_s   = 1'b0;
    ifid_instr_in_s = IMEM_READDATA;
    case (state_q)
      S_REQ: begin
        if (FLUSH) begin
          ifid_bubble_s = 1'b1;
          if (IMEM_BUSYWAIT) begin
            // The access in flight must finish before the target is fetched.
            pend_pc_d = target_s;
            state_d   = S_DRAIN;
          end else begin
            pc_d = target_s;
          end
        end else if (IMEM_BUSYWAIT) begin
          if (!STALL) begin
            ifid_bubble_s = 1'b1;
          end else begin
            ifid_bubble_s = 1'b0;
          end
        end else if (!STALL) begin
          ifid_load_s = 1'b1;
          pc_d        = pc_plus4(pc_q);
        end else begin
          // Memory delivered while decode is frozen: park the word.
          buf_d   = IMEM_READDATA;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        ifid_instr_in_s = buf_q;
        if (FLUSH) begin
          ifid_bubble_s = 1'b1;
          pc_d          = target_s;
          state_d       = S_REQ;
        end else if (!STALL) begin
          ifid_load_s = 1'b1;
          pc_d        = pc_plus4(pc_q);
          state_d     = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (FLUSH) begin
          ifid_bubble_s = 1'b1;
          if (!IMEM_BUSYWAIT) begin
            pc_d    = target_s;
            state_d = S_REQ;
          end else begin
            pend_pc_d = target_s;
          end
        end else if (!IMEM_BUSYWAIT) begin
          pc_d    = pend_pc_q;
          state_d = S_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // pc_q still holds the abandoned address while draining.
  assign IMEM_ADDR  = pc_q;
  assign IMEM_READ  = RESET_N & (state_q != S_HOLD);
  assign FETCH_BUSY = (state_q != S_REQ) | IMEM_BUSYWAIT;

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .load_i   (ifid_load_s),
    .bubble_i (ifid_bubble_s),
    .pc_i     (pc_q),
    .pc4_i    (pc_plus4(pc_q)),
    .instr_i  (ifid_instr_in_s),
    .pc_o     (IFID_PC),
    .pc4_o    (IFID_PC4),
    .instr_o  (IFID_INSTRUCTION),
    .valid_o  (IFID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with an expected-IF/ID queue.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        STALL = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'd0;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_INSTRUCTION;
  logic        IFID_VALID;
  logic        FETCH_BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  ifid_t exp_q[$];
  ifid_t last_exp;

  instruction_fetch_stage dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .IMEM_ADDR        (IMEM_ADDR),
    .IMEM_READ        (IMEM_READ),
    .IMEM_READDATA    (IMEM_READDATA),
    .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
    .STALL            (STALL),
    .FLUSH            (FLUSH),
    .BRANCH_TARGET    (BRANCH_TARGET),
    .IFID_PC          (IFID_PC),
    .IFID_PC4         (IFID_PC4),
    .IFID_INSTRUCTION (IFID_INSTRUCTION),
    .IFID_VALID       (IFID_VALID),
    .FETCH_BUSY       (FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hAE57557A;
      32'h0000_0004: return 32'h54946FBB;
      default:       return 32'h3C00_0000 ^ (a * 32'd7);
    endcase
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDR);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    ifid_t e;
    e.pc = pc;
    e.pc4 = pc + 32'd4;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // mode 0: bubble expected, 1: new instruction from queue, 2: frozen
  task automatic check_ifid(input string tag, input int mode);
    if (mode == 0) begin
      chk({tag, "_valid"}, {31'd0, IFID_VALID}, 32'd0);
      chk({tag, "_nop"}, IFID_INSTRUCTION, NOP);
    end else begin
      if (mode == 1) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      chk({tag, "_valid"}, {31'd0, IFID_VALID}, 32'd1);
      chk({tag, "_pc"}, IFID_PC, last_exp.pc);
      chk({tag, "_pc4"}, IFID_PC4, last_exp.pc4);
      chk({tag, "_instr"}, IFID_INSTRUCTION, last_exp.instr);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic busy, input logic stall, input logic flush, input logic [31:0] tgt);
    IMEM_BUSYWAIT = busy;
    STALL = stall;
    FLUSH = flush;
    BRANCH_TARGET = tgt;
  endtask

  initial begin
    last_exp = '0;
    // 1 reset
    tick();
    tick();
    chk("rst_read", {31'd0, IMEM_READ}, 32'd0);
    check_ifid("rst", 0);
    chk("rst_pc", IFID_PC, 32'd0);
    chk("rst_pc4", IFID_PC4, 32'd0);
    RESET_N = 1'b1;
    #1;
    chk("rel_addr", IMEM_ADDR, 32'h0);
    chk("rel_read", {31'd0, IMEM_READ}, 32'd1);

    // 2 zero-wait streaming
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h0); tick(); check_ifid("zw0", 1);
    push(32'h4); tick(); check_ifid("zw4", 1);
    chk("zw_addr", IMEM_ADDR, 32'h8);

    // 3 two wait states on 0x8
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_ifid("bw1", 0);
    chk("bw_busy", {31'd0, FETCH_BUSY}, 32'd1);
    tick(); check_ifid("bw2", 0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h8); tick(); check_ifid("bw_done", 1);

    // 4 stall three cycles on completing fetch of 0xC
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick(); check_ifid("st1", 2);
    chk("st1_read", {31'd0, IMEM_READ}, 32'd0);
    tick(); check_ifid("st2", 2);
    tick(); check_ifid("st3", 2);
    chk("st3_read", {31'd0, IMEM_READ}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'hC); tick(); check_ifid("st_rel", 1);
    chk("st_next_addr", IMEM_ADDR, 32'h10);
    chk("st_next_read", {31'd0, IMEM_READ}, 32'd1);

    // 5 flush to 0x100 while 0x10 is busy
    drive(1'b1, 1'b0, 1'b1, 32'h100);
    tick(); check_ifid("fl_cyc", 0);
    chk("drain_addr", IMEM_ADDR, 32'h10);
    chk("drain_read", {31'd0, IMEM_READ}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_ifid("drain_wait", 0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick(); check_ifid("drain_done", 0);
    chk("redir_addr", IMEM_ADDR, 32'h100);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick(); check_ifid("redir_wait", 0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h100); tick(); check_ifid("redir_hit", 1);

    // 6 flush+stall in S_HOLD, unaligned target 0x103
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick(); check_ifid("hold6", 2);
    chk("hold6_read", {31'd0, IMEM_READ}, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h103);
    tick(); check_ifid("fl_hold", 0);
    chk("fl_hold_addr", IMEM_ADDR, 32'h100);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h100); tick(); check_ifid("fl_hold_hit", 1);

    // PC wrap at top of address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(); check_ifid("wrap_fl", 0);
    chk("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    push(32'hFFFF_FFFC); tick(); check_ifid("wrap_hit", 1);
    chk("wrap_next", IMEM_ADDR, 32'h0);

    // reset in the middle of a busy access
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_read", {31'd0, IMEM_READ}, 32'd0);
    check_ifid("mid_rst", 0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    RESET_N = 1'b1;
    #1;
    chk("mid_rel_addr", IMEM_ADDR, 32'h0);
    push(32'h0); tick(); check_ifid("mid_first", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
